// File: rtl/adc_apb_pkg.sv
// -----------------------------------------------------------------------------
// adc_apb_pkg
// Shared definitions for the APB ADC controller: register offsets, field
// positions of CTRL / STATUS / IRQ_EN, the CTRL reset image and the APB
// handshake state encoding.
// -----------------------------------------------------------------------------
package adc_apb_pkg;

  // Register byte offsets
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DATA   = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h0C;
  localparam logic [7:0] ADDR_THRESH = 8'h10;

  // CTRL field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_START_BIT = 1;
  localparam int CTRL_AUTO_BIT  = 2;
  localparam int CTRL_GAIN_LSB  = 4;
  localparam int CTRL_RES_LSB   = 6;
  localparam int CTRL_CH_LSB    = 8;
  localparam int CTRL_FLUSH_BIT = 16;

  // STATUS field positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_OVR_BIT   = 3;
  localparam int STAT_THR_BIT   = 4;
  localparam int STAT_LVL_LSB   = 8;

  // IRQ_EN field positions
  localparam int IRQ_EN_THR_BIT = 0;
  localparam int IRQ_EN_OVR_BIT = 1;

  // Reset image of CTRL (resolution code 2'b10, everything else clear)
  localparam logic [31:0] CTRL_RESET = 32'h0000_0080;

  // APB handshake states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_state_e;

endpackage

// File: rtl/adc_result_fifo.sv
// -----------------------------------------------------------------------------
// adc_result_fifo
// Synchronous result FIFO. A push while full is dropped and flagged on
// overflow, unless a pop happens in the same cycle (then both succeed).
// Flush empties the FIFO and discards a push in the same cycle.
// Ports: PCLK, PRESETn (sync, active-low), push/pop/flush, wdata,
//        rdata (head entry), level, full, empty, overflow (one-cycle flag).
// -----------------------------------------------------------------------------
module adc_result_fifo
  import adc_apb_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Status decode and push/pop qualification
  always_comb begin
    full      = (level_r == LW'(DEPTH));
    empty     = (level_r == {LW{1'b0}});
    do_pop_s  = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot the push needs
    do_push_s = push & ~flush & (~full | do_pop_s);
    overflow  = push & ~flush & full & ~do_pop_s;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign level = level_r;

  // Storage array write port
  always_ff @(posedge PCLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge PCLK) begin
    if (!PRESETn || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/apb_adc_ctrl.sv
// -----------------------------------------------------------------------------
// apb_adc_ctrl
// APB slave for the ADC front-end: register file, wait-stated APB handshake
// (SETUP/WAIT/DONE), start request with pending, auto-scan sequencer,
// channel-tagged result FIFO, overrun and threshold interrupts.
// Ports: APB (PCLK, PRESETn, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PRDATA,
//        PREADY, PSLVERR); ADC control (pga_gain, resolution, channel_sel,
//        start_conv, adc_enable); ADC result (adc_data, adc_ch, busy, valid);
//        irq level interrupt.
// -----------------------------------------------------------------------------
module apb_adc_ctrl
  import adc_apb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(NUM_CH),
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [7:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [1:0]        pga_gain,
  output logic [1:0]        resolution,
  output logic [CW-1:0]     channel_sel,
  output logic              start_conv,
  output logic              adc_enable,
  output logic              irq,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [CW-1:0]     adc_ch,
  input  logic              busy,
  input  logic              valid
);

  apb_state_e state_r, state_nxt_s;

  logic [7:0]  acc_addr_r;
  logic [31:0] acc_wdata_r;
  logic        acc_write_r, acc_err_r, acc_pop_r;

  logic        enable_r, auto_mode_r, overrun_r, pending_r;
  logic [1:0]  gain_r, res_r, irq_en_r;
  logic [7:0]  chan_r, thresh_r;
  logic [CW-1:0] scan_r;

  logic [31:0] rd_data_s, ctrl_rd_s, status_rd_s, data_rd_s;
  logic        rd_err_s, wr_err_s, capture_s, commit_s, wr_ok_s;
  logic        wr_ctrl_s, wr_status_s, wr_irq_en_s, wr_thresh_s;
  logic        push_s, pop_s, flush_s, auto_on_s, fire_s, thresh_hit_s;
  logic [7:0]  level8_s;
  logic [CW+DATA_W-1:0] fifo_rdata_s;
  logic [LW-1:0] fifo_level_s;
  logic        fifo_full_s, fifo_empty_s, fifo_ovf_s;
  logic        wdata_unused_s;

  assign wdata_unused_s = ^acc_wdata_r[31:17];

  adc_result_fifo #(
    .WIDTH (CW + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (flush_s),
    .wdata    ({adc_ch, adc_data}),
    .rdata    (fifo_rdata_s),
    .level    (fifo_level_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .overflow (fifo_ovf_s)
  );

  // APB handshake next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (PSEL && !PENABLE) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
      ST_SETUP: if (PSEL && PENABLE)  state_nxt_s = ST_WAIT;  else state_nxt_s = ST_IDLE;
      ST_WAIT:  if (PSEL && PENABLE)  state_nxt_s = ST_DONE;  else state_nxt_s = ST_IDLE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Read images of CTRL, STATUS and DATA
  always_comb begin
    level8_s     = 8'(fifo_level_s);
    thresh_hit_s = (thresh_r != 8'h00) && (level8_s >= thresh_r);

    ctrl_rd_s = 32'h0;
    ctrl_rd_s[CTRL_EN_BIT]          = enable_r;
    ctrl_rd_s[CTRL_AUTO_BIT]        = auto_mode_r;
    ctrl_rd_s[CTRL_GAIN_LSB +: 2]   = gain_r;
    ctrl_rd_s[CTRL_RES_LSB +: 2]    = res_r;
    ctrl_rd_s[CTRL_CH_LSB +: 8]     = chan_r;

    status_rd_s = 32'h0;
    status_rd_s[STAT_BUSY_BIT]      = busy;
    status_rd_s[STAT_EMPTY_BIT]     = fifo_empty_s;
    status_rd_s[STAT_FULL_BIT]      = fifo_full_s;
    status_rd_s[STAT_OVR_BIT]       = overrun_r;
    status_rd_s[STAT_THR_BIT]       = thresh_hit_s;
    status_rd_s[STAT_LVL_LSB +: 8]  = level8_s;

    data_rd_s = 32'h0;
    if (!fifo_empty_s) begin
      data_rd_s[DATA_W-1:0] = fifo_rdata_s[DATA_W-1:0];
      data_rd_s[16 +: CW]   = fifo_rdata_s[DATA_W +: CW];
      data_rd_s[31]         = 1'b1;
    end else begin
      data_rd_s = 32'h0;
    end
  end

  // Address decode: read mux and error flags
  always_comb begin
    rd_data_s = 32'h0;
    rd_err_s  = 1'b0;
    wr_err_s  = 1'b0;
    case (PADDR)
      ADDR_CTRL:   rd_data_s = ctrl_rd_s;
      ADDR_STATUS: rd_data_s = status_rd_s;
      ADDR_DATA: begin
        rd_data_s = data_rd_s;
        wr_err_s  = 1'b1;
      end
      ADDR_IRQ_EN: rd_data_s = {30'h0, irq_en_r};
      ADDR_THRESH: rd_data_s = {24'h0, thresh_r};
      default: begin
        rd_err_s = 1'b1;
        wr_err_s = 1'b1;
      end
    endcase
  end

  // Commit strobes; side effects happen only on the edge that ends DONE
  always_comb begin
    capture_s   = (state_r == ST_WAIT) && (state_nxt_s == ST_DONE);
    commit_s    = (state_r == ST_DONE);
    wr_ok_s     = commit_s && acc_write_r && !acc_err_r;
    wr_ctrl_s   = wr_ok_s && (acc_addr_r == ADDR_CTRL);
    wr_status_s = wr_ok_s && (acc_addr_r == ADDR_STATUS);
    wr_irq_en_s = wr_ok_s && (acc_addr_r == ADDR_IRQ_EN);
    wr_thresh_s = wr_ok_s && (acc_addr_r == ADDR_THRESH);
    pop_s       = commit_s && acc_pop_r;
    flush_s     = wr_ctrl_s && acc_wdata_r[CTRL_FLUSH_BIT];
    push_s      = valid && enable_r;
    auto_on_s   = auto_mode_r && enable_r;
    fire_s      = pending_r && !busy && enable_r;
  end

  // APB state register, access capture and registered bus responses
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r     <= ST_IDLE;
      PRDATA      <= 32'h0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      acc_addr_r  <= 8'h00;
      acc_wdata_r <= 32'h0;
      acc_write_r <= 1'b0;
      acc_err_r   <= 1'b0;
      acc_pop_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        acc_addr_r  <= PADDR;
        acc_wdata_r <= PWDATA;
        acc_write_r <= PWRITE;
        acc_err_r   <= PWRITE ? wr_err_s : rd_err_s;
        // Pop is decided from the head seen now, so a later push cannot be returned
        acc_pop_r   <= !PWRITE && (PADDR == ADDR_DATA) && !fifo_empty_s;
        PRDATA      <= PWRITE ? 32'h0 : rd_data_s;
        PSLVERR     <= PWRITE ? wr_err_s : rd_err_s;
        PREADY      <= 1'b1;
      end else begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end
    end
  end

  // Writable register file
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      enable_r    <= CTRL_RESET[CTRL_EN_BIT];
      auto_mode_r <= CTRL_RESET[CTRL_AUTO_BIT];
      gain_r      <= CTRL_RESET[CTRL_GAIN_LSB +: 2];
      res_r       <= CTRL_RESET[CTRL_RES_LSB +: 2];
      chan_r      <= CTRL_RESET[CTRL_CH_LSB +: 8];
      irq_en_r    <= 2'b00;
      thresh_r    <= 8'h01;
    end else begin
      if (wr_ctrl_s) begin
        enable_r    <= acc_wdata_r[CTRL_EN_BIT];
        auto_mode_r <= acc_wdata_r[CTRL_AUTO_BIT];
        gain_r      <= acc_wdata_r[CTRL_GAIN_LSB +: 2];
        res_r       <= acc_wdata_r[CTRL_RES_LSB +: 2];
        chan_r      <= acc_wdata_r[CTRL_CH_LSB +: 8];
      end
      if (wr_irq_en_s) begin
        irq_en_r <= acc_wdata_r[1:0];
      end
      if (wr_thresh_s) begin
        thresh_r <= acc_wdata_r[7:0];
      end
    end
  end

  // Sticky overrun; a new overflow wins over a simultaneous clear
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      overrun_r <= 1'b0;
    end else if (fifo_ovf_s) begin
      overrun_r <= 1'b1;
    end else if (wr_status_s && acc_wdata_r[STAT_OVR_BIT]) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Start request: single pending flag launched as a pulse once the converter is idle
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pending_r  <= 1'b0;
      start_conv <= 1'b0;
    end else begin
      start_conv <= fire_s;
      if (wr_ctrl_s && !acc_wdata_r[CTRL_EN_BIT]) begin
        pending_r <= 1'b0;
      end else if (wr_ctrl_s && acc_wdata_r[CTRL_START_BIT]) begin
        pending_r <= 1'b1;
      end else if (!enable_r || fire_s) begin
        pending_r <= 1'b0;
      end else if (auto_on_s && !busy) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Auto-scan channel counter; held at 0 outside auto mode so entry restarts the scan
  always_ff @(posedge PCLK) begin
    if (!PRESETn || !auto_on_s) begin
      scan_r <= {CW{1'b0}};
    end else if (valid) begin
      scan_r <= (scan_r == CW'(NUM_CH - 1)) ? {CW{1'b0}} : scan_r + CW'(1);
    end else begin
      scan_r <= scan_r;
    end
  end

  // Registered ADC control outputs and interrupt
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pga_gain    <= 2'b00;
      resolution  <= 2'b10;
      adc_enable  <= 1'b0;
      channel_sel <= {CW{1'b0}};
      irq         <= 1'b0;
    end else begin
      pga_gain    <= gain_r;
      resolution  <= res_r;
      adc_enable  <= enable_r;
      channel_sel <= auto_on_s ? scan_r : chan_r[CW-1:0];
      irq         <= (irq_en_r[IRQ_EN_THR_BIT] && thresh_hit_s) ||
                     (irq_en_r[IRQ_EN_OVR_BIT] && overrun_r);
    end
  end

endmodule

// File: tb/tb_apb_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_adc_ctrl
// Directed self-checking bench for apb_adc_ctrl (NUM_CH=4, DATA_W=16,
// FIFO_DEPTH=8). Inputs change 1 time unit after the rising edge, outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_apb_adc_ctrl;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_VALID  = 1;
  localparam int MODE_ABORT  = 2;
  localparam int MODE_RESET  = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  pga_gain, resolution;
  logic [1:0]  channel_sel;
  logic        start_conv, adc_enable, irq;
  logic [15:0] adc_data;
  logic [1:0]  adc_ch;
  logic        busy, valid;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;
  logic [31:0] rd;
  logic        err;

  always #5 PCLK = ~PCLK;

  apb_adc_ctrl #(
    .NUM_CH     (4),
    .DATA_W     (16),
    .FIFO_DEPTH (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .pga_gain    (pga_gain),
    .resolution  (resolution),
    .channel_sel (channel_sel),
    .start_conv  (start_conv),
    .adc_enable  (adc_enable),
    .irq         (irq),
    .adc_data    (adc_data),
    .adc_ch      (adc_ch),
    .busy        (busy),
    .valid       (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; mode selects a valid pulse in DONE, an abort in WAIT or a reset in DONE
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input int mode, output logic [31:0] rdata, output logic rerr);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    if (mode == MODE_ABORT) begin
      PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b0;
      check("abort_no_ready", {31'h0, PREADY}, 32'h0);
      @(posedge PCLK); #1;
      rdata = PRDATA;
      rerr  = PSLVERR;
    end else begin
      n = 0;
      while (PREADY !== 1'b1 && n < 6) begin
        @(posedge PCLK); #1;
        n++;
      end
      check("ready_latency", n, 32'd1);
      rdata = PRDATA;
      rerr  = PSLVERR;
      if (mode == MODE_VALID) valid = 1'b1;
      if (mode == MODE_RESET) PRESETn = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; valid = 1'b0;
    end
  endtask

  initial begin
    PRESETn = 1'b0; PADDR = 8'h00; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = 32'h0; adc_data = 16'h0; adc_ch = 2'd0; busy = 1'b0; valid = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    // Reset state
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_outs", {16'h0, PREADY, PSLVERR, pga_gain, resolution, channel_sel,
                       start_conv, adc_enable, irq, 5'h0}, {16'h0, 1'b0, 1'b0, 2'b00, 2'b10,
                       2'b00, 1'b0, 1'b0, 1'b0, 5'h0});
    PRESETn = 1'b1;

    apb(1'b0, 8'h00, 32'h0, MODE_NORMAL, rd, err); check("rst_ctrl", rd, 32'h0000_0080);
    apb(1'b0, 8'h04, 32'h0, MODE_NORMAL, rd, err); check("rst_status", rd, 32'h0000_0002);
    apb(1'b0, 8'h0C, 32'h0, MODE_NORMAL, rd, err); check("rst_irq_en", rd, 32'h0);
    apb(1'b0, 8'h10, 32'h0, MODE_NORMAL, rd, err); check("rst_thresh", rd, 32'h1);
    check("rst_thresh_err", {31'h0, err}, 32'h0);
    apb(1'b0, 8'h20, 32'h0, MODE_NORMAL, rd, err); check("unmapped_rd", rd, 32'h0);
    check("unmapped_err", {31'h0, err}, 32'h1);
    apb(1'b0, 8'h02, 32'h0, MODE_NORMAL, rd, err); check("unaligned_err", {31'h0, err}, 32'h1);
    apb(1'b1, 8'h08, 32'h5, MODE_NORMAL, rd, err); check("ro_write_err", {31'h0, err}, 32'h1);

    // Start held while busy, single pulse after busy falls
    busy = 1'b1;
    apb(1'b1, 8'h00, 32'h0000_0003, MODE_NORMAL, rd, err);
    check("ctrl_wr_err", {31'h0, err}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      check("no_start_busy", {31'h0, start_conv}, 32'h0);
    end
    busy = 1'b0;
    @(posedge PCLK); #1;
    check("start_pulse", {31'h0, start_conv}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      if (start_conv) pulses++;
    end
    check("start_single", pulses, 32'd0);
    check("ctrl_outs", {28'h0, resolution, adc_enable, 1'b0}, {28'h0, 2'b00, 1'b1, 1'b0});
    apb(1'b0, 8'h00, 32'h0, MODE_NORMAL, rd, err); check("ctrl_rb_start0", rd, 32'h0000_0001);

    // Auto scan, FIFO fill and overrun
    apb(1'b1, 8'h0C, 32'h2, MODE_NORMAL, rd, err);
    apb(1'b1, 8'h00, 32'h0000_0005, MODE_NORMAL, rd, err);
    @(posedge PCLK); #1;
    for (int i = 0; i < 9; i++) begin
      check("scan_ch", {30'h0, channel_sel}, i % 4);
      adc_ch = 2'(i % 4); adc_data = 16'hA000 + 16'(i);
      valid = 1'b1;
      @(posedge PCLK); #1;
      valid = 1'b0;
      @(posedge PCLK); #1;
    end
    check("irq_overrun", {31'h0, irq}, 32'h1);
    apb(1'b0, 8'h04, 32'h0, MODE_NORMAL, rd, err); check("status_full_ovr", rd, 32'h0000_081C);

    // W1C overrun, irq drops one cycle after the commit edge
    apb(1'b1, 8'h04, 32'h8, MODE_NORMAL, rd, err);
    check("w1c_err", {31'h0, err}, 32'h0);
    check("irq_w1c_lag", {31'h0, irq}, 32'h1);
    @(posedge PCLK); #1;
    check("irq_w1c_drop", {31'h0, irq}, 32'h0);

    // Pop and push on the same edge while full
    adc_ch = 2'd1; adc_data = 16'hB001;
    apb(1'b0, 8'h08, 32'h0, MODE_VALID, rd, err);
    check("data_oldest", rd, 32'h8000_A000);
    apb(1'b0, 8'h04, 32'h0, MODE_NORMAL, rd, err); check("status_pushpop", rd, 32'h0000_0814);
    check("irq_no_ovr", {31'h0, irq}, 32'h0);

    // Flush, manual channel, threshold interrupt
    apb(1'b1, 8'h00, 32'h0001_0271, MODE_NORMAL, rd, err);
    @(posedge PCLK); #1;
    check("manual_outs", {26'h0, pga_gain, resolution, channel_sel}, {26'h0, 2'd3, 2'd1, 2'd2});
    apb(1'b0, 8'h04, 32'h0, MODE_NORMAL, rd, err); check("status_flushed", rd, 32'h0000_0002);
    apb(1'b1, 8'h10, 32'h3, MODE_NORMAL, rd, err);
    apb(1'b1, 8'h0C, 32'h1, MODE_NORMAL, rd, err);
    adc_ch = 2'd2; adc_data = 16'h0011; valid = 1'b1; @(posedge PCLK); #1; valid = 1'b0;
    @(posedge PCLK); #1;
    adc_ch = 2'd3; adc_data = 16'h0022; valid = 1'b1; @(posedge PCLK); #1; valid = 1'b0;
    @(posedge PCLK); #1;
    check("irq_below_thr", {31'h0, irq}, 32'h0);
    adc_ch = 2'd1; adc_data = 16'h0033; valid = 1'b1; @(posedge PCLK); #1; valid = 1'b0;
    check("irq_thr_lag", {31'h0, irq}, 32'h0);
    @(posedge PCLK); #1;
    check("irq_thr", {31'h0, irq}, 32'h1);
    apb(1'b0, 8'h08, 32'h0, MODE_NORMAL, rd, err);
    check("data_thr_read", rd, 32'h8002_0011);
    check("irq_pop_lag", {31'h0, irq}, 32'h1);
    @(posedge PCLK); #1;
    check("irq_pop_drop", {31'h0, irq}, 32'h0);

    // Aborted CTRL write leaves CTRL unchanged
    apb(1'b1, 8'h00, 32'h0000_00F0, MODE_ABORT, rd, err);
    apb(1'b0, 8'h00, 32'h0, MODE_NORMAL, rd, err); check("ctrl_after_abort", rd, 32'h0000_0271);

    // Reset during DONE of a DATA read
    apb(1'b0, 8'h08, 32'h0, MODE_RESET, rd, err);
    check("data_before_rst", rd, 32'h8003_0022);
    check("rst_mid_outs", {30'h0, PREADY, irq}, 32'h0);
    PRESETn = 1'b1;
    apb(1'b0, 8'h04, 32'h0, MODE_NORMAL, rd, err); check("status_after_rst", rd, 32'h0000_0002);
    apb(1'b0, 8'h00, 32'h0, MODE_NORMAL, rd, err); check("ctrl_after_rst", rd, 32'h0000_0080);
    apb(1'b0, 8'h08, 32'h0, MODE_NORMAL, rd, err); check("data_empty", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_adc_ctrl.md
# apb_adc_ctrl

Parametrised APB slave controlling the programmable ADC front-end, successor to the fixed four-register control block. It adds an N-channel auto-scan sequencer, a result FIFO tagged with channel number, and a proper wait-stated APB handshake with PSLVERR. The block also provides sticky overrun detection, threshold and overrun interrupts, and a start request that is held pending while the converter is busy. It sits between the SoC APB fabric and the ADC core (PGA, SAR, sequencer).

## Interface
- NUM_CH, 4: analog channels, 2..256; CW = $clog2(NUM_CH)
- DATA_W, 16: ADC result width, 8..16
- FIFO_DEPTH, 8: result FIFO entries, power of 2, 2..128; LW = $clog2(FIFO_DEPTH+1)
- PCLK  in  1  sole clock
- PRESETn  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- PADDR  in  8  byte address
- PSEL, PENABLE, PWRITE  in  1  APB controls
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  transfer complete, registered
- PSLVERR  out  1  error, valid only while PREADY=1
- pga_gain  out  2  PGA gain code
- resolution  out  2  ADC resolution code
- channel_sel  out  CW  channel for next conversion
- start_conv  out  1  one-cycle conversion start pulse
- adc_enable  out  1  ADC core enable
- irq  out  1  level interrupt, registered
- adc_data  in  DATA_W  conversion result
- adc_ch  in  CW  channel of the result
- busy  in  1  conversion in progress
- valid  in  1  one-cycle pulse; result present

## Operation
- Register map. Unmapped or unaligned offsets: read 0, PSLVERR=1. Writes to RO offsets: PSLVERR=1, no effect.
  - 0x00 CTRL RW, reset 0x0000_0080. Fields: [0] enable; [1] start (W1, reads 0); [2] auto_mode; [5:4] pga_gain; [7:6] resolution; [15:8] channel (low CW bits used); [16] flush (W1, reads 0).
  - 0x04 STATUS, RO except bit [3] W1C: [0] busy; [1] empty; [2] full; [3] overrun (sticky); [4] thresh_hit; [15:8] level.
  - 0x08 DATA RO. Fields: [DATA_W-1:0] data; [23:16] channel; [31] valid. A read that returns valid=1 pops the FIFO. Reading when empty returns 0 and does not pop.
  - 0x0C IRQ_EN RW, reset 0: [0] threshold; [1] overrun.
  - 0x10 THRESH RW [7:0], reset 1. A value of 0 disables thresh_hit.
- APB FSM states:
  - IDLE → SETUP on PSEL & !PENABLE.
  - SETUP → WAIT on PSEL & PENABLE; otherwise → IDLE.
  - WAIT (PREADY=0; PRDATA and PSLVERR captured here) → DONE if PSEL & PENABLE; otherwise → IDLE with no side effects.
  - DONE (PREADY=1) → IDLE.
  - Write commit and DATA pop occur at the clock edge ending DONE.
- Start handling:
  - A start write with enable=1 sets a single pending flag; a repeat write while already pending is absorbed.
  - start_conv pulses on the first cycle with pending & !busy; the flag clears in the same cycle.
  - enable=0 clears pending and inhibits start_conv.
- Auto mode (auto_mode & enable):
  - The sequencer raises pending whenever !busy and no pending request exists.
  - channel_sel scans 0..NUM_CH-1, advancing on each valid and wrapping NUM_CH-1→0.
  - Entering auto mode restarts the scan from channel 0.
- Manual mode: channel_sel = CTRL.channel[CW-1:0].
- FIFO behaviour:
  - Push {adc_ch, adc_data} on valid & enable.
  - Push while full drops the sample and sets overrun.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Flush sets level to 0; a push in the flush cycle is discarded.
- thresh_hit = (THRESH≠0) & (level ≥ THRESH).
- irq = (IRQ_EN[0] & thresh_hit) | (IRQ_EN[1] & overrun).

## Timing
- Reset values: PRDATA 0; PREADY 0; PSLVERR 0; pga_gain 0; resolution 2'b10; channel_sel 0; start_conv 0; adc_enable 0; irq 0. FIFO empty, overrun 0, pending 0, FSM IDLE.
- Reset asserted mid-transfer aborts the transfer with no commit.
- APB transfer takes 3 cycles: SETUP, WAIT, DONE.
- CTRL-derived outputs update 1 cycle after the commit edge.
- start_conv fires at the earliest 1 cycle after commit, or 1 cycle after busy falls if the start was pending.
- valid → level and STATUS change: 1 cycle. irq follows its cause by 1 cycle.
- DATA read: the entry shown in PRDATA is the FIFO head at the WAIT edge. A push arriving during WAIT is not returned by that read.

## Structure
- Package adc_apb_pkg: register offsets, CTRL/STATUS/IRQ_EN bit positions, CTRL reset constant, FSM state enum.
- Sub-module adc_result_fifo: parametrised synchronous FIFO with push, pop, flush, level, full, empty and simultaneous push/pop on full.
- Top-level owns the APB FSM, register file, start/pending logic, scan counter and irq.

## Test plan
- Reset, then read every register → CTRL 0x80, STATUS 0x0000_0002, IRQ_EN 0, THRESH 1. Read 0x20 → PRDATA 0, PSLVERR=1.
- Write CTRL=0x0000_0003 with busy=1 for 5 cycles → no start_conv while busy. Exactly one pulse on the cycle after busy falls.
- NUM_CH=4, auto mode, 9 valid pulses → channel_sel sequence 0,1,2,3,0,1,2,3,0. FIFO holds the first 8; the 9th sets overrun; with IRQ_EN=2, irq=1.
- Full FIFO, valid coincident with the DATA pop edge → no overrun, level stays 8. W1C 0x08 to STATUS → overrun 0, irq drops 1 cycle later.
- THRESH=3, IRQ_EN=1, push 3 samples → irq=1. One DATA read returns valid=1 with the oldest channel/data; irq drops.
- PENABLE deasserted during WAIT on a CTRL write → CTRL unchanged. Reset during DONE of a DATA read → no pop, FIFO empty after reset.
